// File: rtl/uart_pkg.sv
// Shared UART constants and state encoding, common to the transmit and
// receive ends of the host link so both agree on bit timing.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int CLK_PER_BIT_DEF = 87;
    localparam int FRAME_BITS      = 10;
    localparam int DATA_BITS       = 8;

    function automatic int frame_cycles(input int clk_per_bit);
        return FRAME_BITS * clk_per_bit;
    endfunction

endpackage

// File: rtl/uart_tx_word_if.sv
// Start handshake and line/status signals of the word transmitter.
interface uart_tx_word_if;

    logic        tx_start;
    logic [15:0] tx_data;
    logic        serial_out;
    logic        tx_busy;
    logic        tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  serial_out,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output serial_out,
        output tx_busy,
        output tx_done
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: one-cycle tick on the last clock of every bit,
// held at zero while restart is asserted so each frame starts aligned.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = CLK_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int            CW   = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (restart || (count_q == LAST)) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == LAST);

endmodule

// File: rtl/uart_tx_word.sv
// 8N1 UART transmitter sending a 16-bit word as back-to-back frames,
// high byte first, data bits MSB-first, with a registered line output.
module uart_tx_word
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT    = CLK_PER_BIT_DEF,
    parameter int BYTES_PER_WORD = 2
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_word_if.slave  tx_if
);

    localparam logic LAST_BYTE = (BYTES_PER_WORD == 2) ? 1'b1 : 1'b0;

    uart_state_e state_q;
    uart_state_e state_d;
    logic [15:0] shift_q;
    logic [15:0] shift_d;
    logic [2:0]  bit_idx_q;
    logic [2:0]  bit_idx_d;
    logic        byte_idx_q;
    logic        byte_idx_d;
    logic        serial_q;
    logic        serial_d;
    logic        busy_q;
    logic        busy_d;
    logic        done_q;
    logic        done_d;

    logic        bit_tick;
    logic [7:0]  cur_byte;

    // The byte on the wire always sits in the top half of the shift register.
    assign cur_byte = shift_q[15:8];

    uart_baud_tick #(
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (state_q == IDLE),
        .tick    (bit_tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        serial_d   = serial_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                serial_d = 1'b1;
                if (tx_if.tx_start) begin
                    shift_d    = (BYTES_PER_WORD == 1) ? {tx_if.tx_data[7:0], 8'h00}
                                                       : tx_if.tx_data;
                    byte_idx_d = 1'b0;
                    bit_idx_d  = 3'd7;
                    serial_d   = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_tick) begin
                    serial_d = cur_byte[bit_idx_q];
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_idx_q == 3'd0) begin
                        serial_d = 1'b1;
                        state_d  = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q - 3'd1;
                        serial_d  = cur_byte[bit_idx_q - 3'd1];
                    end
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (byte_idx_q < LAST_BYTE) begin
                        // Next frame's start bit follows the stop bit directly.
                        byte_idx_d = byte_idx_q + 1'b1;
                        bit_idx_d  = 3'd7;
                        shift_d    = {shift_q[7:0], 8'h00};
                        serial_d   = 1'b0;
                        state_d    = START;
                    end else begin
                        serial_d = 1'b1;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                serial_d = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= 1'b0;
            serial_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            serial_q   <= serial_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_if.serial_out = serial_q;
    assign tx_if.tx_busy    = busy_q;
    assign tx_if.tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_word.sv
// Directed bench for uart_tx_word: fast-bit instances for cycle-exact line
// checks and a default-rate instance looped back into a serial receiver.
module tb_uart_tx_word;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    uart_tx_word_if if4 ();
    uart_tx_word_if if87 ();
    uart_tx_word_if if1 ();

    uart_tx_word #(.CLK_PER_BIT(4),  .BYTES_PER_WORD(2)) dut4  (.clk(clk), .rst(rst), .tx_if(if4));
    uart_tx_word #(.CLK_PER_BIT(87), .BYTES_PER_WORD(2)) dut87 (.clk(clk), .rst(rst), .tx_if(if87));
    uart_tx_word #(.CLK_PER_BIT(4),  .BYTES_PER_WORD(1)) dut1  (.clk(clk), .rst(rst), .tx_if(if1));

    // Expected line level in cycle k (1 = first cycle after acceptance).
    function automatic logic exp_bit(input logic [15:0] w, input int nbytes, input int k, input int cpb);
        int b;
        int pos;
        logic [7:0] by;
        b   = (k - 1) / cpb;
        pos = b % 10;
        by  = (nbytes == 2 && b < 10) ? w[15:8] : w[7:0];
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return by[8 - pos];
    endfunction

    // Mid-bit sampling receiver on the 87-cycle line.
    logic [7:0] rx_q[$];
    int         rx_stop_bad = 0;
    initial begin
        logic [7:0] sh;
        forever begin
            @(negedge if87.serial_out);
            repeat (43) @(posedge clk);
            #1;
            if (if87.serial_out !== 1'b0) continue;
            sh = 8'h00;
            for (int b = 0; b < 8; b++) begin
                repeat (87) @(posedge clk);
                #1;
                sh = {sh[6:0], if87.serial_out};
            end
            repeat (87) @(posedge clk);
            #1;
            if (if87.serial_out !== 1'b1) rx_stop_bad++;
            rx_q.push_back(sh);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        if4.tx_start = 1'b0;  if4.tx_data = 16'h0;
        if87.tx_start = 1'b0; if87.tx_data = 16'h0;
        if1.tx_start = 1'b0;  if1.tx_data = 16'h0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({if4.serial_out, if4.tx_busy, if4.tx_done} !== 3'b100) begin
            errors++; $display("FAIL reset_dut4: got line/busy/done=%b exp 100", {if4.serial_out, if4.tx_busy, if4.tx_done});
        end
        checks++; if ({if87.serial_out, if87.tx_busy, if87.tx_done} !== 3'b100) begin
            errors++; $display("FAIL reset_dut87: got line/busy/done=%b exp 100", {if87.serial_out, if87.tx_busy, if87.tx_done});
        end
        checks++; if ({if1.serial_out, if1.tx_busy, if1.tx_done} !== 3'b100) begin
            errors++; $display("FAIL reset_dut1: got line/busy/done=%b exp 100", {if1.serial_out, if1.tx_busy, if1.tx_done});
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("test_reset done");
    endtask

    task automatic test_basic_word();
        logic [19:0] exp_line;
        exp_line = 20'b0101001011_0001111001;
        if4.tx_data = 16'hA53C; if4.tx_start = 1'b1;
        @(posedge clk); #1; if4.tx_start = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            checks++; if (if4.serial_out !== exp_line[19 - (k - 1) / 4] || if4.tx_busy !== 1'b1 || if4.tx_done !== 1'b0) begin
                errors++; $display("FAIL basic_line cycle %0d: got line/busy/done=%b%b%b exp %b10", k,
                                   if4.serial_out, if4.tx_busy, if4.tx_done, exp_line[19 - (k - 1) / 4]);
            end
            @(posedge clk); #1;
        end
        checks++; if ({if4.serial_out, if4.tx_busy, if4.tx_done} !== 3'b101) begin
            errors++; $display("FAIL basic_done: got line/busy/done=%b exp 101", {if4.serial_out, if4.tx_busy, if4.tx_done});
        end
        @(posedge clk); #1;
        checks++; if (if4.tx_done !== 1'b0) begin
            errors++; $display("FAIL basic_done_pulse: got done=%b exp 0", if4.tx_done);
        end
        $display("test_basic_word: sent A53C");
    endtask

    task automatic test_loopback();
        logic [15:0] words [2];
        logic [7:0]  exp_bytes [4];
        int n;
        words = '{16'h00FF, 16'h8001};
        exp_bytes = '{8'h00, 8'hFF, 8'h80, 8'h01};
        rx_q.delete();
        for (int w = 0; w < 2; w++) begin
            if87.tx_data = words[w]; if87.tx_start = 1'b1;
            @(posedge clk); #1; if87.tx_start = 1'b0;
            n = 0;
            while (if87.tx_done !== 1'b1 && n < 2000) begin
                @(posedge clk); #1; n++;
            end
            checks++; if (if87.tx_done !== 1'b1 || n != 1740) begin
                errors++; $display("FAIL loop_done word %0d: got done=%b after %0d cycles exp 1 after 1740", w, if87.tx_done, n);
            end
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                checks++; if (if87.serial_out !== 1'b1 || if87.tx_busy !== 1'b0) begin
                    errors++; $display("FAIL loop_idle: got line/busy=%b%b exp 10", if87.serial_out, if87.tx_busy);
                end
            end
            $display("test_loopback: sent %h", words[w]);
        end
        checks++; if (rx_q.size() != 4) begin
            errors++; $display("FAIL loop_count: got %0d bytes exp 4", rx_q.size());
        end
        for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_bytes[i]) begin
                errors++; $display("FAIL loop_byte %0d: got %h exp %h", i, rx_q[i], exp_bytes[i]);
            end
        end
        checks++; if (rx_stop_bad != 0) begin
            errors++; $display("FAIL loop_stop: got %0d bad stop bits exp 0", rx_stop_bad);
        end
    endtask

    task automatic test_busy_ignore();
        int dones;
        dones = 0;
        rx_q.delete();
        if87.tx_data = 16'h1234; if87.tx_start = 1'b1;
        @(posedge clk); #1; if87.tx_start = 1'b0;
        for (int c = 1; c <= 2000; c++) begin
            if (c == 100) begin if87.tx_data = 16'hFFFF; if87.tx_start = 1'b1; end
            if (c == 101) if87.tx_start = 1'b0;
            if (if87.tx_done === 1'b1) dones++;
            @(posedge clk); #1;
        end
        checks++; if (dones != 1) begin
            errors++; $display("FAIL busy_done_count: got %0d exp 1", dones);
        end
        checks++; if (rx_q.size() != 2) begin
            errors++; $display("FAIL busy_rx_count: got %0d exp 2", rx_q.size());
        end else begin
            checks++; if (rx_q[0] !== 8'h12 || rx_q[1] !== 8'h34) begin
                errors++; $display("FAIL busy_rx_bytes: got %h %h exp 12 34", rx_q[0], rx_q[1]);
            end
        end
        $display("test_busy_ignore: sent 1234, FFFF pulse while busy");
    endtask

    task automatic test_back_to_back();
        int n;
        if4.tx_data = 16'h1234; if4.tx_start = 1'b1;
        @(posedge clk); #1; if4.tx_start = 1'b0;
        n = 0;
        while (if4.tx_done !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        checks++; if (if4.tx_done !== 1'b1 || n != 80) begin
            errors++; $display("FAIL b2b_first_done: got done=%b after %0d cycles exp 1 after 80", if4.tx_done, n);
        end
        if4.tx_data = 16'h5555; if4.tx_start = 1'b1;
        @(posedge clk); #1; if4.tx_start = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            checks++; if (if4.serial_out !== exp_bit(16'h5555, 2, k, 4) || if4.tx_busy !== 1'b1) begin
                errors++; $display("FAIL b2b_line cycle %0d: got line/busy=%b%b exp %b1", k,
                                   if4.serial_out, if4.tx_busy, exp_bit(16'h5555, 2, k, 4));
            end
            @(posedge clk); #1;
        end
        checks++; if (if4.tx_done !== 1'b1 || if4.tx_busy !== 1'b0) begin
            errors++; $display("FAIL b2b_done: got done/busy=%b%b exp 10", if4.tx_done, if4.tx_busy);
        end
        $display("test_back_to_back: sent 1234 then 5555");
    endtask

    task automatic test_reset_mid();
        int dones;
        int highs_bad;
        if4.tx_data = 16'hA53C; if4.tx_start = 1'b1;
        @(posedge clk); #1; if4.tx_start = 1'b0;
        repeat (21) begin @(posedge clk); #1; end
        checks++; if (if4.serial_out !== 1'b0 || if4.tx_busy !== 1'b1) begin
            errors++; $display("FAIL rstmid_bit3: got line/busy=%b%b exp 01", if4.serial_out, if4.tx_busy);
        end
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        checks++; if ({if4.serial_out, if4.tx_busy, if4.tx_done} !== 3'b100) begin
            errors++; $display("FAIL rstmid_after: got line/busy/done=%b exp 100", {if4.serial_out, if4.tx_busy, if4.tx_done});
        end
        dones = 0; highs_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (if4.tx_done === 1'b1) dones++;
            if (if4.serial_out !== 1'b1) highs_bad++;
        end
        checks++; if (dones != 0 || highs_bad != 0) begin
            errors++; $display("FAIL rstmid_quiet: got %0d dones %0d low cycles exp 0 0", dones, highs_bad);
        end
        if4.tx_data = 16'h0F0F; if4.tx_start = 1'b1;
        @(posedge clk); #1; if4.tx_start = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            checks++; if (if4.serial_out !== exp_bit(16'h0F0F, 2, k, 4) || if4.tx_done !== 1'b0) begin
                errors++; $display("FAIL rstmid_line cycle %0d: got line/done=%b%b exp %b0", k,
                                   if4.serial_out, if4.tx_done, exp_bit(16'h0F0F, 2, k, 4));
            end
            @(posedge clk); #1;
        end
        checks++; if (if4.tx_done !== 1'b1) begin
            errors++; $display("FAIL rstmid_done: got done=%b exp 1", if4.tx_done);
        end
        $display("test_reset_mid: aborted A53C, sent 0F0F");
    endtask

    task automatic test_one_byte();
        logic [9:0] exp_line;
        exp_line = 10'b0100000011;
        if1.tx_data = 16'hFF81; if1.tx_start = 1'b1;
        @(posedge clk); #1; if1.tx_start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            checks++; if (if1.serial_out !== exp_line[9 - (k - 1) / 4] || if1.tx_busy !== 1'b1 || if1.tx_done !== 1'b0) begin
                errors++; $display("FAIL onebyte_line cycle %0d: got line/busy/done=%b%b%b exp %b10", k,
                                   if1.serial_out, if1.tx_busy, if1.tx_done, exp_line[9 - (k - 1) / 4]);
            end
            @(posedge clk); #1;
        end
        checks++; if ({if1.serial_out, if1.tx_busy, if1.tx_done} !== 3'b101) begin
            errors++; $display("FAIL onebyte_done: got line/busy/done=%b exp 101", {if1.serial_out, if1.tx_busy, if1.tx_done});
        end
        $display("test_one_byte: sent FF81");
    endtask

    initial begin
        test_reset();
        test_basic_word();
        test_loopback();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_one_byte();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
